// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
package mem_arb_pkg;

  // Arbiter sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GNT_IF  = 3'd1,
    ST_GNT_MA  = 3'd2,
    ST_RESP_IF = 3'd3,
    ST_RESP_MA = 3'd4
  } arb_state_e;

  // Width of the anti-starvation streak counter (MAX_STREAK is at most 15).
  localparam int STREAK_W = 4;

  // MA wins a cycle in IDLE unless IF is waiting and MA has used up its streak.
  function automatic logic ma_wins(input logic                if_req,
                                   input logic [STREAK_W-1:0] streak,
                                   input logic [STREAK_W-1:0] max_streak);
    return !if_req || (streak < max_streak);
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Unified memory-port arbiter: shares one single-ported memory between the
// instruction fetch (IF) and load/store (MA) stages, one access at a time.
//
// Handshake: every request (iw_if_req, iw_ma_req, ow_mem_req) is a level that
// the initiator holds, with its address/data stable, until the matching
// one-cycle completion pulse (ow_if_ack, ow_ma_ack, iw_mem_ack). Response data
// is valid in the ack cycle. A requester may drop or change its request in its
// own ack cycle; the arbiter only samples requests in IDLE.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 24,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_ack,
  output logic [DATA_W-1:0] ow_if_data,
  input  logic              iw_ma_req,
  input  logic              iw_ma_we,
  input  logic [ADDR_W-1:0] iw_ma_addr,
  input  logic [DATA_W-1:0] iw_ma_wdata,
  output logic              ow_ma_ack,
  output logic [DATA_W-1:0] ow_ma_rdata,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_ack,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic              ow_if_stall,
  output logic              ow_ma_stall,
  output logic              ow_err,
  output logic [2:0]        ow_dbg_state
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam int                  WD_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit                  WD_EN      = (TIMEOUT != 0);
  // Last grant cycle index allowed before the access is aborted.
  localparam logic [WD_W-1:0]     WD_LAST    = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic [WD_W-1:0]     wdog;

  // Stalls follow the requests combinationally so the pipeline sees them at once.
  assign ow_if_stall  = iw_if_req && !ow_if_ack;
  assign ow_ma_stall  = iw_ma_req && !ow_ma_ack;
  assign ow_dbg_state = state;

  // Arbitration, memory sequencing, streak and watchdog counters.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state        <= ST_IDLE;
      streak       <= '0;
      wdog         <= '0;
      ow_if_ack    <= 1'b0;
      ow_if_data   <= '0;
      ow_ma_ack    <= 1'b0;
      ow_ma_rdata  <= '0;
      ow_mem_req   <= 1'b0;
      ow_mem_we    <= 1'b0;
      ow_mem_addr  <= '0;
      ow_mem_wdata <= '0;
      ow_err       <= 1'b0;
    end else begin
      ow_if_ack <= 1'b0;
      ow_ma_ack <= 1'b0;
      ow_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!iw_if_req) streak <= '0;
          if (iw_ma_req && ma_wins(iw_if_req, streak, STREAK_MAX)) begin
            state        <= ST_GNT_MA;
            ow_mem_req   <= 1'b1;
            ow_mem_we    <= iw_ma_we;
            ow_mem_addr  <= iw_ma_addr;
            ow_mem_wdata <= iw_ma_wdata;
            wdog         <= '0;
            // Only reachable with streak below the limit, so this saturates.
            if (iw_if_req) streak <= streak + 1'b1;
          end else if (iw_if_req) begin
            state        <= ST_GNT_IF;
            ow_mem_req   <= 1'b1;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= iw_if_addr;
            ow_mem_wdata <= '0;
            wdog         <= '0;
            streak       <= '0;
          end
        end
        ST_GNT_IF, ST_GNT_MA: begin
          if (iw_mem_ack) begin
            // A memory ack on the last watchdog cycle still completes normally.
            ow_mem_req <= 1'b0;
            if (state == ST_GNT_IF) begin
              ow_if_data <= iw_mem_rdata;
              ow_if_ack  <= 1'b1;
              state      <= ST_RESP_IF;
            end else begin
              if (!ow_mem_we) ow_ma_rdata <= iw_mem_rdata;
              ow_ma_ack <= 1'b1;
              state     <= ST_RESP_MA;
            end
          end else if (WD_EN && (wdog == WD_LAST)) begin
            ow_mem_req <= 1'b0;
            ow_err     <= 1'b1;
            if (state == ST_GNT_IF) begin
              ow_if_data <= '0;
              ow_if_ack  <= 1'b1;
              state      <= ST_RESP_IF;
            end else begin
              ow_ma_rdata <= '0;
              ow_ma_ack   <= 1'b1;
              state       <= ST_RESP_MA;
            end
          end else if (WD_EN) begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_RESP_IF, ST_RESP_MA: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb against a transaction-timeline reference model.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW   = 24;
  localparam int DW   = 24;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_data;
  logic          ma_req = 1'b0;
  logic          ma_we = 1'b0;
  logic [AW-1:0] ma_addr = '0;
  logic [DW-1:0] ma_wdata = '0;
  logic          ma_ack;
  logic [DW-1:0] ma_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_stall;
  logic          ma_stall;
  logic          err;
  logic [2:0]    dbg_state;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_if_req(if_req), .iw_if_addr(if_addr), .ow_if_ack(if_ack), .ow_if_data(if_data),
    .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
    .ow_ma_ack(ma_ack), .ow_ma_rdata(ma_rdata),
    .ow_mem_req(mem_req), .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
    .iw_mem_ack(mem_ack), .iw_mem_rdata(mem_rdata),
    .ow_if_stall(if_stall), .ow_ma_stall(ma_stall), .ow_err(err), .ow_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Requesters
  bit            if_pend = 0, ma_pend = 0;
  logic [AW-1:0] if_a, ma_a;
  logic          ma_w;
  logic [DW-1:0] ma_wd;
  // Memory contents
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  // Current access timeline: decided at cycle g_cyc, memory ack at mack_cyc,
  // requester ack at resp_cyc; aborted accesses run TMO grant cycles.
  bit            busy = 0, own_ma = 0, abort = 0;
  int            g_cyc = 0, mack_cyc = 0, resp_cyc = 0;
  logic          own_we;
  logic [AW-1:0] own_a;
  logic [DW-1:0] own_wd;
  int            ma_run = 0;  // consecutive MA wins while IF waited
  logic [DW-1:0] exp_if_data = '0, exp_ma_rdata = '0;
  // Knobs
  int p_if = 0, p_ma = 0, max_lat = 0, p_hang = 0;
  bit release_req = 0;

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 24'h000010;
      1:       return 24'h000020;
      2:       return 24'h000040;
      default: return AW'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic grant(input bit to_ma);
    int lat;
    busy   = 1;
    own_ma = to_ma;
    own_we = to_ma ? ma_w : 1'b0;
    own_a  = to_ma ? ma_a : if_a;
    own_wd = ma_wd;
    g_cyc  = cyc;
    lat    = ($urandom_range(0, 99) < p_hang) ? TMO + 5 : $urandom_range(0, max_lat);
    abort  = (lat >= TMO);
    if (abort) begin
      resp_cyc = cyc + 1 + TMO;
      exp_q.push_back('0);
    end else begin
      mack_cyc = cyc + 1 + lat;
      resp_cyc = cyc + 2 + lat;
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    bit exp_mreq, exp_ifa, exp_maa, exp_err;
    @(posedge clk);
    #1;
    cyc++;
    exp_mreq = busy && (cyc > g_cyc) && (cyc <= (abort ? g_cyc + TMO : mack_cyc));
    exp_ifa  = busy && (cyc == resp_cyc) && !own_ma;
    exp_maa  = busy && (cyc == resp_cyc) && own_ma;
    exp_err  = busy && (cyc == resp_cyc) && abort;
    if (busy && cyc == resp_cyc) begin
      check_eq("sb_depth", DW'(exp_q.size()), DW'(1));
      if (exp_q.size() != 0) begin
        logic [DW-1:0] d;
        d = exp_q.pop_front();
        if (!own_ma) exp_if_data = d;
        else if (abort || !own_we) exp_ma_rdata = d;
      end
    end
    check_eq("mem_req", DW'(mem_req), DW'(exp_mreq));
    check_eq("if_ack", DW'(if_ack), DW'(exp_ifa));
    check_eq("ma_ack", DW'(ma_ack), DW'(exp_maa));
    check_eq("err", DW'(err), DW'(exp_err));
    check_eq("if_data", if_data, exp_if_data);
    check_eq("ma_rdata", ma_rdata, exp_ma_rdata);
    if (exp_mreq) begin
      check_eq("mem_we", DW'(mem_we), DW'(own_we));
      check_eq("mem_addr", DW'(mem_addr), DW'(own_a));
      if (own_we) check_eq("mem_wdata", mem_wdata, own_wd);
    end

    if (release_req) begin
      rst_n = 1'b1;
      release_req = 0;
    end

    // Requesters: retire on ack, possibly re-request in the same cycle.
    if (exp_ifa) if_pend = 0;
    if (exp_maa) ma_pend = 0;
    if (!if_pend && $urandom_range(0, 99) < p_if) begin
      if_pend = 1;
      if_a    = rand_addr();
    end
    if (!ma_pend && $urandom_range(0, 99) < p_ma) begin
      ma_pend = 1;
      ma_a    = rand_addr();
      ma_w    = 1'($urandom_range(0, 1));
      ma_wd   = DW'($urandom);
    end
    if_req   = if_pend;
    if_addr  = if_pend ? if_a : AW'($urandom);
    ma_req   = ma_pend;
    ma_we    = ma_pend ? ma_w : 1'b0;
    ma_addr  = ma_pend ? ma_a : AW'($urandom);
    ma_wdata = ma_pend ? ma_wd : DW'($urandom);

    // Memory responder; stray acks outside a grant must be ignored.
    mem_ack   = 1'b0;
    mem_rdata = DW'($urandom);
    if (busy && !abort && cyc == mack_cyc) begin
      mem_ack = 1'b1;
      if (own_we) begin
        mem_model[own_a] = own_wd;
        exp_q.push_back(own_wd);
      end else begin
        if (!mem_model.exists(own_a)) mem_model[own_a] = DW'($urandom);
        mem_rdata = mem_model[own_a];
        exp_q.push_back(mem_rdata);
      end
    end else if (!exp_mreq && $urandom_range(0, 5) == 0) begin
      mem_ack = 1'b1;
    end

    // Arbitration happens in cycles where no access is in progress.
    if (rst_n && !busy) begin
      if (!if_req) ma_run = 0;
      if (ma_req && (!if_req || ma_run < MAXS)) begin
        if (if_req) ma_run++;
        grant(1);
      end else if (if_req) begin
        ma_run = 0;
        grant(0);
      end
    end else if (busy && cyc == resp_cyc) begin
      busy = 0;
    end

    #1;
    check_eq("if_stall", DW'(if_stall), DW'(if_req && !exp_ifa));
    check_eq("ma_stall", DW'(ma_stall), DW'(ma_req && !exp_maa));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    ma_pend = 0;
    ma_req  = 1'b0;
    #1;
    busy = 0;
    ma_run = 0;
    exp_if_data = '0;
    exp_ma_rdata = '0;
    exp_q.delete();
    check_eq("rst_mem_req", DW'(mem_req), DW'(0));
    check_eq("rst_state", DW'(dbg_state), DW'(ST_IDLE));
    check_eq("rst_if_data", if_data, '0);
    check_eq("rst_if_stall", DW'(if_stall), DW'(if_req));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    repeat (3) step();
    check_eq("init_state", DW'(dbg_state), DW'(ST_IDLE));
    release_req = 1;

    // Mixed traffic, short latencies.
    p_if = 40; p_ma = 40; max_lat = 3; p_hang = 0;
    repeat (300) step();

    // Both requesters saturated: MA streak bounded, IF still progresses.
    p_if = 100; p_ma = 100; max_lat = 1;
    repeat (120) step();

    // Latencies up to the watchdog boundary plus hung accesses.
    p_if = 50; p_ma = 50; max_lat = TMO - 1; p_hang = 15;
    repeat (200) step();

    // Reset in the middle of an IF grant with a hung memory.
    p_if = 100; p_ma = 0; p_hang = 100;
    n = 0;
    while (!(busy && !own_ma && cyc >= g_cyc + 3) && n < 60) begin
      step();
      n++;
    end
    check_eq("reach_gnt_if", DW'(busy && !own_ma), DW'(1));
    assert_reset();
    repeat (2) step();
    p_hang = 0; max_lat = 2;
    release_req = 1;
    step();
    check_eq("regrant_if", DW'(busy && !own_ma && g_cyc == cyc), DW'(1));
    step();
    check_eq("regrant_mem_req", DW'(mem_req), DW'(1));

    // Tail of mixed traffic after reset.
    p_if = 50; p_ma = 50;
    repeat (150) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
